// File: rtl/fft_pkg.sv
// Shared constants for the streaming FFT datapath (sink-side feeder and
// source-side capture).
//   FFT_LENGTH : points per frame (power of two, >= 8)
//   DW         : signed width of one real/imag component
//   MAG_W      : width of the |re|+|im| magnitude estimate
//   ST_*       : capture FSM state encodings
package fft_pkg;

  localparam int FFT_LENGTH = 256;
  localparam int DW         = 18;
  localparam int MAG_W      = DW + 1;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/fft_mag_ram.sv
// Simple dual-port magnitude buffer: one synchronous write port, one
// synchronous read port with a registered output.
//   clk, rst      : clock, synchronous active-high reset (output reg only)
//   we/waddr/wdata: write port
//   raddr/rdata   : read port, rdata valid one cycle after raddr
// Reading the address being written returns the old contents.
module fft_mag_ram #(
  parameter int DEPTH = fft_pkg::FFT_LENGTH / 2,
  parameter int WIDTH = fft_pkg::MAG_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Storage is deliberately not reset so it maps onto block RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_source_capture.sv
// Source-side consumer of the streaming FFT core. Takes one frame per
// packet, forms |re|+|im| per bin, buffers bins 0..FFT_LENGTH/2-1 and
// reports the strongest non-DC bin of each good frame.
//   clk, rst                 : clock, synchronous active-high reset
//   source_*                 : FFT core source stream (valid/ready/sop/eop/error)
//   i_rd_addr / o_rd_data    : buffer read port, 1-cycle latency
//   o_frame_done/o_frame_err : one-cycle status pulses
//   o_peak_bin/o_peak_mag    : peak of the last good frame
module fft_source_capture #(
  parameter int FFT_LENGTH = fft_pkg::FFT_LENGTH,
  parameter int DW         = fft_pkg::DW
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [DW-1:0]            source_real,
  input  logic signed [DW-1:0]            source_imag,
  input  logic                            source_valid,
  input  logic                            source_startofpacket,
  input  logic                            source_endofpacket,
  input  logic [1:0]                      source_error,
  output logic                            source_ready,
  input  logic [$clog2(FFT_LENGTH)-2:0]   i_rd_addr,
  output logic [DW:0]                     o_rd_data,
  output logic                            o_frame_done,
  output logic                            o_frame_err,
  output logic [$clog2(FFT_LENGTH)-2:0]   o_peak_bin,
  output logic [DW:0]                     o_peak_mag
);

  import fft_pkg::*;

  localparam int MW = DW + 1;
  localparam int CW = $clog2(FFT_LENGTH);
  localparam int AW = CW - 1;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           acc, poison;

  logic [MW-1:0]  re_x, im_x, re_abs, im_abs, mag_d;
  logic [MW-1:0]  mag_q;
  logic [CW-1:0]  mag_bin;
  logic           mag_vld;

  logic [MW-1:0]  run_mag;
  logic [AW-1:0]  run_bin;
  logic           ram_we;

  // Ready follows the state directly so the core sees 0 while rst is held
  // and 1 on the first cycle out of reset.
  assign source_ready = ~rst & (state == ST_IDLE | state == ST_CAPTURE);
  assign acc          = source_valid & source_ready;
  assign poison       = |source_error;

  // Sign-extend by one bit before negating so that -2^(DW-1) maps to
  // +2^(DW-1) without overflow; the sum of two such values fits in MW.
  always_comb begin
    re_x   = {source_real[DW-1], source_real};
    im_x   = {source_imag[DW-1], source_imag};
    re_abs = re_x[MW-1] ? (~re_x + 1'b1) : re_x;
    im_abs = im_x[MW-1] ? (~im_x + 1'b1) : im_x;
    mag_d  = re_abs + im_abs;
  end

  always_ff @(posedge clk) begin
    if (acc) mag_q <= mag_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      mag_vld      <= 1'b0;
      mag_bin      <= '0;
      run_mag      <= '0;
      run_bin      <= AW'(1);
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      o_peak_bin   <= '0;
      o_peak_mag   <= '0;
    end else begin
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      mag_vld      <= 1'b0;

      // Peak compare on the registered magnitude; lower half, DC excluded.
      // Bins arrive in order, so strict '>' keeps the lowest index on ties.
      // A sop in the case below overrides this update.
      if (mag_vld && !mag_bin[CW-1] && mag_bin != '0 && mag_q > run_mag) begin
        run_mag <= mag_q;
        run_bin <= mag_bin[AW-1:0];
      end

      case (state)
        ST_IDLE: begin
          if (acc && source_startofpacket) begin
            if (poison) begin
              o_frame_err <= 1'b1;
            end else begin
              state   <= ST_CAPTURE;
              cnt     <= CW'(1);
              mag_vld <= 1'b1;
              mag_bin <= '0;
              run_mag <= '0;
              run_bin <= AW'(1);
            end
          end
        end
        ST_CAPTURE: begin
          if (acc) begin
            if (poison) begin
              o_frame_err <= 1'b1;
              state       <= ST_IDLE;
            end else if (source_startofpacket) begin
              // Restart: abandon the current frame, this beat is bin 0.
              o_frame_err <= 1'b1;
              cnt         <= CW'(1);
              mag_vld     <= 1'b1;
              mag_bin     <= '0;
              run_mag     <= '0;
              run_bin     <= AW'(1);
            end else begin
              mag_vld <= 1'b1;
              mag_bin <= cnt;
              cnt     <= cnt + 1'b1;
              if (source_endofpacket) begin
                if (cnt == CW'(FFT_LENGTH - 1)) begin
                  state <= ST_DRAIN;
                end else begin
                  o_frame_err <= 1'b1;
                  state       <= ST_IDLE;
                end
              end
            end
          end
        end
        ST_DRAIN: begin
          state        <= ST_DONE;
          o_frame_done <= 1'b1;
          o_peak_bin   <= run_bin;
          o_peak_mag   <= run_mag;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign ram_we = mag_vld & ~mag_bin[CW-1];

  fft_mag_ram #(
    .DEPTH (FFT_LENGTH / 2),
    .WIDTH (MW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (mag_bin[AW-1:0]),
    .wdata (mag_q),
    .raddr (i_rd_addr),
    .rdata (o_rd_data)
  );

endmodule

// File: tb/tb_fft_source_capture.sv
module tb_fft_source_capture;

  localparam int N    = 256;
  localparam int HALF = N / 2;

  logic               clk;
  logic               rst;
  logic signed [17:0] source_real, source_imag;
  logic               source_valid, source_startofpacket, source_endofpacket;
  logic [1:0]         source_error;
  logic               source_ready;
  logic [6:0]         i_rd_addr;
  logic [18:0]        o_rd_data;
  logic               o_frame_done, o_frame_err;
  logic [6:0]         o_peak_bin;
  logic [18:0]        o_peak_mag;

  fft_source_capture dut (
    .clk                  (clk),
    .rst                  (rst),
    .source_real          (source_real),
    .source_imag          (source_imag),
    .source_valid         (source_valid),
    .source_startofpacket (source_startofpacket),
    .source_endofpacket   (source_endofpacket),
    .source_error         (source_error),
    .source_ready         (source_ready),
    .i_rd_addr            (i_rd_addr),
    .o_rd_data            (o_rd_data),
    .o_frame_done         (o_frame_done),
    .o_frame_err          (o_frame_err),
    .o_peak_bin           (o_peak_bin),
    .o_peak_mag           (o_peak_mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit done;
    int bin;
    int mag;
  } exp_t;

  exp_t sbq[$];
  int   n_chk, n_fail;
  int   fre [N];
  int   fim [N];
  int   exp_buf [HALF];
  int   g_bin, g_mag;
  bit   mon_en;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mag(input int re, input int im);
    return (re < 0 ? -re : re) + (im < 0 ? -im : im);
  endfunction

  task automatic sb_push(input bit done, input int bin, input int m);
    exp_t e;
    e.done = done; e.bin = bin; e.mag = m;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Holds the beat until an edge where ready was high (checked mid-cycle).
  task automatic send_beat(input int re, input int im, input bit sop,
                           input bit eop, input logic [1:0] err);
    int t;
    bit r;
    source_valid = 1'b1; source_real = 18'(re); source_imag = 18'(im);
    source_startofpacket = sop; source_endofpacket = eop; source_error = err;
    t = 0;
    do begin
      @(negedge clk); r = source_ready;
      @(posedge clk); t++;
    end while (!r && t < 64);
    if (!r) chk("ready_timeout", 0, 1);
    #1;
    source_valid = 1'b0; source_startofpacket = 1'b0;
    source_endofpacket = 1'b0; source_error = 2'b00;
  endtask

  task automatic fill_zero();
    for (int b = 0; b < N; b++) begin fre[b] = 0; fim[b] = 0; end
  endtask

  task automatic fill_rand();
    for (int b = 0; b < N; b++) begin
      fre[b] = int'($urandom_range(0, 4000)) - 2000;
      fim[b] = int'($urandom_range(0, 4000)) - 2000;
    end
  endtask

  // Sends bins 0..last; eop on the last beat if do_eop; error code on err_at.
  task automatic run_frame(input int last, input bit do_eop, input int err_at,
                           input int gap_pct);
    int pb, pm, m;
    bit e, eo;
    pb = 1; pm = 0;
    for (int b = 0; b <= last; b++) begin
      e  = (b == err_at);
      eo = do_eop && (b == last);
      m  = mag(fre[b], fim[b]);
      if (!e && b < HALF) exp_buf[b] = m;
      if (!e && b >= 1 && b < HALF && m > pm) begin pm = m; pb = b; end
      if (e) sb_push(1'b0, g_bin, g_mag);
      else if (eo && last == N - 1) begin
        g_bin = pb; g_mag = pm; sb_push(1'b1, pb, pm);
      end else if (eo) sb_push(1'b0, g_bin, g_mag);
      if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct)
        idle(int'($urandom_range(1, 3)));
      send_beat(fre[b], fim[b], b == 0, eo, e ? 2'b01 : 2'b00);
      if (e) break;
    end
  endtask

  task automatic rd_chk(input int a);
    i_rd_addr = 7'(a);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("rd_data[%0d]", a), o_rd_data, exp_buf[a]);
    @(posedge clk); #1;
  endtask

  // Pulse monitor: pops the scoreboard on every status pulse, checks pulse
  // width and the ready bubble length after each completed frame.
  initial begin
    int   lowrun;
    bit   pd, pe;
    exp_t e;
    lowrun = 0; pd = 0; pe = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        lowrun = 0; pd = 0; pe = 0;
      end else begin
        if (!source_ready) lowrun++;
        else if (lowrun != 0) begin
          chk("ready_bubble", lowrun, 2);
          lowrun = 0;
        end
        if (o_frame_done) chk("done_width", pd, 0);
        if (o_frame_err)  chk("err_width", pe, 0);
        if (o_frame_done || o_frame_err) begin
          if (sbq.size() == 0) chk("unexpected_pulse", 1, 0);
          else begin
            e = sbq.pop_front();
            chk("pulse_kind", o_frame_done, e.done);
            chk("pulse_kind_err", o_frame_err, !e.done);
            chk("peak_bin", o_peak_bin, e.bin);
            chk("peak_mag", o_peak_mag, e.mag);
          end
        end
        pd = o_frame_done; pe = o_frame_err;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; mon_en = 0; g_bin = 0; g_mag = 0;
    rst = 1'b1; source_valid = 1'b0; source_real = '0; source_imag = '0;
    source_startofpacket = 1'b0; source_endofpacket = 1'b0;
    source_error = 2'b00; i_rd_addr = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", source_ready, 0);
    chk("rst_done", o_frame_done, 0);
    chk("rst_err", o_frame_err, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", source_ready, 1);
    chk("post_rst_peak_bin", o_peak_bin, 0);
    chk("post_rst_peak_mag", o_peak_mag, 0);
    chk("post_rst_rd_data", o_rd_data, 0);
    mon_en = 1;
    @(posedge clk); #1;

    // Single tone at bin 10.
    fill_zero(); fre[10] = 1000; fim[10] = -500;
    run_frame(N - 1, 1, -1, 0); idle(4);
    rd_chk(10); rd_chk(0); rd_chk(127);

    // DC excluded, tie between bins 5 and 9 goes to 5.
    fill_zero(); fre[0] = 5000; fre[5] = 300; fre[9] = -100; fim[9] = 200;
    run_frame(N - 1, 1, -1, 0); idle(4);
    rd_chk(0); rd_chk(5); rd_chk(9);

    // Most negative inputs; large upper-half bin must be ignored.
    fill_zero(); fre[3] = -131072; fim[3] = -131072; fre[200] = 131071; fim[200] = 131071;
    run_frame(N - 1, 1, -1, 0); idle(4);
    rd_chk(3);

    // Early eop: discarded, peak holds.
    fill_rand();
    run_frame(100, 1, -1, 0); idle(4);

    // Stray non-sop beats in IDLE are dropped, then a gappy random frame.
    repeat (3) send_beat(7, 7, 0, 0, 2'b00);
    fill_rand();
    run_frame(N - 1, 1, -1, 30); idle(4);
    rd_chk(1); rd_chk(64);

    // Three back-to-back frames with valid held high.
    for (int f = 0; f < 3; f++) begin
      fill_rand();
      run_frame(N - 1, 1, -1, 0);
    end
    idle(4);
    rd_chk(17); rd_chk(126);

    // Error code mid-frame, then a clean frame.
    fill_rand();
    run_frame(N - 1, 1, 50, 0); idle(4);
    fill_zero(); fre[77] = -4000; fim[77] = 25;
    run_frame(N - 1, 1, -1, 0); idle(4);
    rd_chk(77);

    // Mid-frame sop restarts the frame with an error pulse.
    fill_rand();
    run_frame(40, 0, -1, 0);
    sb_push(1'b0, g_bin, g_mag);
    fill_rand();
    run_frame(N - 1, 1, -1, 10); idle(4);
    rd_chk(2);

    // Reset mid-frame: no pulses, peak outputs cleared.
    fill_rand();
    run_frame(60, 0, -1, 0);
    mon_en = 0; rst = 1'b1;
    idle(2);
    rst = 1'b0; g_bin = 0; g_mag = 0;
    @(negedge clk);
    chk("midrst_peak_bin", o_peak_bin, 0);
    chk("midrst_peak_mag", o_peak_mag, 0);
    chk("midrst_ready", source_ready, 1);
    mon_en = 1;
    @(posedge clk); #1;
    fill_zero(); fre[120] = 9; fim[120] = -9;
    run_frame(N - 1, 1, -1, 0); idle(6);

    chk("sb_remaining", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
